// File: rtl/aes_pkg.sv
// aes_pkg: mode encodings, FSM states and sizing helpers for the AES key schedule
package aes_pkg;
  localparam logic [1:0] MODE_128 = 2'd0;
  localparam logic [1:0] MODE_192 = 2'd1;
  localparam logic [1:0] MODE_256 = 2'd2;
  localparam logic [1:0] MODE_RSV = 2'd3;
  localparam int TBL_DEPTH_MAX = 60;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_GEN, ST_DONE} state_t;
  function automatic int tbl_depth(int max_nk);
    return 4 * (max_nk + 7);
  endfunction
  function automatic logic [3:0] mode_nk(logic [1:0] mode);
    return mode == MODE_128 ? 4'd4 : mode == MODE_192 ? 4'd6 : mode == MODE_256 ? 4'd8 : 4'd0;
  endfunction
  function automatic logic [3:0] mode_nr(logic [1:0] mode);
    return mode_nk(mode) + 4'd6;
  endfunction
endpackage

// File: rtl/aes_key_expand_seq_word_gen.sv
// aes_key_word_gen: next key-schedule word from w[i-1], w[i-Nk] and the step type
module aes_key_word_gen (
  input  logic [31:0] w_prev,
  input  logic [31:0] w_back,
  input  logic [31:0] rcon,
  input  logic        rot_sub,
  input  logic        sub_only,
  output logic [31:0] w_next
);
  logic [31:0] s_in, s_out;
  assign s_in = rot_sub ? {w_prev[23:0], w_prev[31:24]} : w_prev;
  for (genvar b = 0; b < 4; b++) begin : g_sb
    aes_sbox u_sbox (.a(s_in[8*b +: 8]), .q(s_out[8*b +: 8]));
  end
  assign w_next = w_back ^ (rot_sub ? s_out ^ rcon : sub_only ? s_out : w_prev);
endmodule

// File: rtl/aes_rcon.sv
// aes_rcon: round constant word for a 1-based rcon index
module aes_rcon (
  input  logic [3:0]  rnd,
  output logic [31:0] rcon
);
  localparam logic [0:15][7:0] RC = 128'h00010204_08102040_801b3600_00000000;
  assign rcon = {RC[rnd], 24'h0};
endmodule

// File: rtl/aes_sbox.sv
// aes_sbox: AES forward S-box lookup
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] q
);
  localparam logic [0:255][7:0] SB = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  assign q = SB[a];
endmodule

// File: rtl/aes_key_expand_seq.sv
// aes_key_expand_seq: one-word-per-cycle AES-128/192/256 key expansion into a readable round-key table
module aes_key_expand_seq
  import aes_pkg::*;
#(
  parameter int MAX_NK = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ip_start,
  input  logic [1:0]   ip_mode,
  input  logic [255:0] ip_key,
  input  logic [3:0]   ip_rd_rnd,
  output logic         op_busy,
  output logic         op_ready,
  output logic         op_err,
  output logic [3:0]   op_nr,
  output logic [127:0] op_rkey
);
  localparam int DEPTH = tbl_depth(MAX_NK);
  localparam logic [3:0] MAX_NK_L = 4'(MAX_NK);
  state_t state, state_nx;
  logic [3:0] nk, nr, nk_m1, rc_idx, start_nk;
  logic [2:0] wrap;
  logic [5:0] idx, last, rd_base;
  logic [255:0] key;
  logic [31:0] tbl [DEPTH];
  logic [31:0] rcon, w_next;
  logic idle, legal, start_ok, start_bad, err;
  assign start_nk = mode_nk(ip_mode);
  assign idle = state == ST_IDLE || state == ST_DONE;
  assign legal = ip_mode != MODE_RSV && start_nk <= MAX_NK_L;
  assign start_ok = idle && ip_start && legal;
  assign start_bad = idle && ip_start && !legal;
  assign nk_m1 = nk - 4'd1;
  assign last = {nr, 2'b11};
  always_comb begin
    state_nx = start_ok ? ST_LOAD :
               state == ST_LOAD ? ST_GEN :
               (state == ST_GEN && idx == last) ? ST_DONE : state;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      nk    <= '0;
      nr    <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      err   <= start_bad;
      if (start_ok) begin
        nk <= start_nk;
        nr <= mode_nr(ip_mode);
      end
    end
  end
  // Datapath needs no reset: nothing here is visible until state reaches DONE.
  always_ff @(posedge clk) begin
    if (start_ok) key <= ip_key;
    if (state == ST_LOAD) begin
      idx    <= {2'b00, nk};
      wrap   <= '0;
      rc_idx <= 4'd1;
      for (int k = 0; k < 8; k++)
        if (4'(k) < nk) tbl[6'(k)] <= key[255 - 32*k -: 32];
    end else if (state == ST_GEN) begin
      idx       <= idx + 6'd1;
      wrap      <= {1'b0, wrap} == nk_m1 ? 3'd0 : wrap + 3'd1;
      rc_idx    <= rc_idx + {3'd0, wrap == 3'd0};
      tbl[idx]  <= w_next;
    end
  end
  aes_rcon u_rcon (.rnd(rc_idx), .rcon(rcon));
  aes_key_word_gen u_gen (
    .w_prev  (tbl[idx - 6'd1]),
    .w_back  (tbl[idx - {2'b00, nk}]),
    .rcon    (rcon),
    .rot_sub (wrap == 3'd0),
    .sub_only(nk == 4'd8 && wrap == 3'd4),
    .w_next  (w_next)
  );
  assign rd_base  = {ip_rd_rnd, 2'b00};
  assign op_busy  = state == ST_LOAD || state == ST_GEN;
  assign op_ready = state == ST_DONE;
  assign op_err   = err;
  assign op_nr    = nr;
  assign op_rkey  = (op_ready && ip_rd_rnd <= nr) ?
                    {tbl[rd_base], tbl[rd_base | 6'd1], tbl[rd_base | 6'd2], tbl[rd_base | 6'd3]} : '0;
endmodule

// File: tb/tb_aes_key_expand_seq.sv
// tb_aes_key_expand_seq: scoreboard bench with FIPS-197 key-expansion vectors
module tb_aes_key_expand_seq;
  import aes_pkg::*;
  localparam logic [255:0] K128 = {128'h2b7e1516_28aed2a6_abf71588_09cf4f3c, {4{32'hdeadbeef}}};
  localparam logic [255:0] K192 = {192'h8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b, 64'hffff_ffff_ffff_ffff};
  localparam logic [255:0] K256 = 256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;
  localparam logic [255:0] KC   = {128'h00010203_04050607_08090a0b_0c0d0e0f, 128'h0};
  localparam logic [127:0] R1_128 = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
  logic clk = 1'b0, rst_n = 1'b0, ip_start = 1'b0, ip_start4 = 1'b0;
  logic [1:0] ip_mode = 2'd0;
  logic [255:0] ip_key = '0;
  logic [3:0] ip_rd_rnd = 4'd0;
  logic op_busy, op_ready, op_err, b4, r4, e4;
  logic [3:0] op_nr, nr4;
  logic [127:0] op_rkey, k4;
  typedef struct {string name; int kind; logic [127:0] exp;} chk_t;
  chk_t sb_q[$];
  int lat_q[$];
  int n_vec = 0, n_bad = 0;
  time t0 = 0;
  logic prev_ready = 1'b0;
  always #5 clk = ~clk;
  aes_key_expand_seq dut (
    .clk(clk), .rst_n(rst_n), .ip_start(ip_start), .ip_mode(ip_mode), .ip_key(ip_key),
    .ip_rd_rnd(ip_rd_rnd), .op_busy(op_busy), .op_ready(op_ready), .op_err(op_err),
    .op_nr(op_nr), .op_rkey(op_rkey));
  aes_key_expand_seq #(.MAX_NK(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .ip_start(ip_start4), .ip_mode(ip_mode), .ip_key(ip_key),
    .ip_rd_rnd(ip_rd_rnd), .op_busy(b4), .op_ready(r4), .op_err(e4),
    .op_nr(nr4), .op_rkey(k4));
  function automatic logic [127:0] fl(logic b, logic r, logic e, logic [3:0] nr);
    return {121'd0, b, r, e, nr};
  endfunction
  // Monitor: drains every queued expectation against the outputs of this cycle.
  always @(negedge clk) begin
    chk_t c;
    logic [127:0] act;
    int cyc, want;
    while (sb_q.size() > 0) begin
      c = sb_q.pop_front();
      act = c.kind == 0 ? op_rkey : c.kind == 1 ? fl(op_busy, op_ready, op_err, op_nr) : fl(b4, r4, e4, nr4);
      n_vec++;
      if (act !== c.exp) begin
        n_bad++;
        $display("FAIL %s: got %h, want %h", c.name, act, c.exp);
      end
    end
    if (op_ready === 1'b1 && prev_ready !== 1'b1) begin
      cyc = int'(($time - t0) / 10);
      n_vec++;
      if (lat_q.size() == 0) begin
        n_bad++;
        $display("FAIL latency: op_ready rose after %0d cycles, want no completion", cyc);
      end else begin
        want = lat_q.pop_front();
        if (cyc != want) begin
          n_bad++;
          $display("FAIL latency: got %0d cycles, want %0d", cyc, want);
        end
      end
    end
    prev_ready = op_ready;
  end
  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(string name, int kind, logic [127:0] exp);
    chk_t c;
    c.name = name;
    c.kind = kind;
    c.exp  = exp;
    sb_q.push_back(c);
  endtask
  task automatic rd(string name, logic [3:0] r, logic [127:0] exp);
    ip_rd_rnd = r;
    chk(name, 0, exp);
    step();
  endtask
  task automatic start(logic [1:0] m, logic [255:0] k, int lat);
    ip_start = 1'b1;
    ip_mode  = m;
    ip_key   = k;
    if (lat > 0) lat_q.push_back(lat);
    @(posedge clk);
    t0 = $time;
    #1;
    ip_start = 1'b0;
    ip_mode  = 2'd3;
    ip_key   = ~k;
  endtask
  task automatic wait_ready(string name);
    int n = 0;
    while (op_ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    if (op_ready !== 1'b1) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: op_ready=%b after 100 cycles, want 1", name, op_ready);
    end
  endtask
  initial begin
    step(3);
    chk("reset_flags", 1, fl(0, 0, 0, 0));
    chk("reset_rkey", 0, '0);
    rst_n = 1'b1;
    step();
    ip_start4 = 1'b1; ip_mode = MODE_256; step(); ip_start4 = 1'b0;
    chk("nk_guard_err", 2, fl(0, 0, 1, 0)); step();
    chk("nk_guard_clear", 2, fl(0, 0, 0, 0));
    ip_start4 = 1'b1; ip_mode = MODE_128; step(); ip_start4 = 1'b0;
    chk("nk_guard_128_ok", 2, fl(1, 0, 0, 10)); step();
    start(MODE_128, K128, 41);
    chk("busy_128", 1, fl(1, 0, 0, 10));
    rd("rkey_while_busy", 1, '0);
    step(8);
    ip_start = 1'b1; ip_mode = MODE_256; ip_key = K256; step(); ip_start = 1'b0;
    chk("busy_after_pulse", 1, fl(1, 0, 0, 10));
    wait_ready("ready_128");
    chk("done_128", 1, fl(0, 1, 0, 10));
    rd("r0_128", 0, 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c);
    rd("r1_128", 1, R1_128);
    rd("r10_128", 10, 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6);
    rd("r11_128", 11, '0);
    start(MODE_RSV, K256, 0);
    chk("err_pulse", 1, fl(0, 1, 1, 10));
    step();
    chk("err_clear", 1, fl(0, 1, 0, 10));
    rd("r1_after_err", 1, R1_128);
    start(MODE_192, K192, 47);
    wait_ready("ready_192");
    chk("done_192", 1, fl(0, 1, 0, 12));
    rd("r1_192", 1, 128'h62f8ead2_522c6b7b_fe0c91f7_2402f5a5);
    rd("r12_192", 12, 128'he98ba06f_448c773c_8ecc7204_01002202);
    rd("r13_192", 13, '0);
    start(MODE_256, K256, 53);
    wait_ready("ready_256");
    chk("done_256", 1, fl(0, 1, 0, 14));
    rd("r2_256", 2, 128'h9ba35411_8e6925af_a51a8b5f_2067fcde);
    rd("r3_256", 3, 128'ha8b09c1a_93d194cd_be49846e_b75d5b9a);
    rd("r14_256", 14, 128'hfe4890d1_e6188d0b_046df344_706c631e);
    start(MODE_128, KC, 41);
    chk("restart_low", 1, fl(1, 0, 0, 10));
    rd("restart_rkey", 2, '0);
    wait_ready("ready_restart");
    rd("r1_restart", 1, 128'hd6aa74fd_d2af72fa_daa678f1_d6ab76fe);
    rd("r10_restart", 10, 128'h13111d7f_e3944a17_f307a78b_4d2b30c5);
    start(MODE_128, K128, 0);
    step(20);
    rst_n = 1'b0;
    step();
    ip_rd_rnd = 4'd1;
    chk("abort_flags", 1, fl(0, 0, 0, 0));
    chk("abort_rkey", 0, '0);
    step();
    rst_n = 1'b1;
    step(3);
    n_vec++;
    if (lat_q.size() != 0) begin
      n_bad++;
      $display("FAIL pending_latency: %0d completions outstanding, want 0", lat_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
